// File: rtl/cf_ata_device.sv
// cf_ata_device: card-side CompactFlash True-IDE responder with a 256-word PIO sector buffer.
// Define CF_ATA_DEVICE_IDENTIFY_EN to enable the IDENTIFY DEVICE (0xEC) command.
module cf_ata_device #(
  parameter int unsigned SECTORS = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ata_reset_n,
  input  logic [1:0]  ata_cs_n,
  input  logic [2:0]  ata_addr,
  input  logic        ata_iord_n,
  input  logic        ata_iowr_n,
  input  logic [15:0] ata_data_in,
  output logic [15:0] ata_data_out,
  output logic        ata_data_oe,
  output logic        ata_intrq,
  output logic        ata_iordy,
  output logic        st_cmd_valid,
  input  logic        st_cmd_ready,
  output logic        st_cmd_write,
  output logic [27:0] st_cmd_lba,
  input  logic [15:0] st_rd_data,
  input  logic        st_rd_valid,
  output logic [15:0] st_wr_data,
  output logic        st_wr_valid,
  input  logic        st_wr_ready
);

  localparam logic [31:0] SECT32 = 32'(SECTORS);

  typedef enum logic [2:0] {IDLE, RD_FETCH, RD_XFER, WR_XFER, WR_FLUSH, ID_FILL} state_t;
  state_t state, next_state;

  logic [1:0]  ares_sync;
  logic        rst_any;
  logic        iord_s1, iord_s2, iord_s3, iowr_s1, iowr_s2, iowr_s3;
  logic [1:0]  cs_s1, cs_s2, cs_s3;
  logic [2:0]  addr_s1, addr_s2, addr_s3;
  logic [15:0] data_s1, data_s2, data_s3;

  logic [15:0] buffer [256];
  logic [7:0]  count, device, error, ptr;
  logic [23:0] lba;
  logic [8:0]  wcnt;
  logic        err, nien, srst, pending, ident, cmd_done, rd_done;

  logic        rd_evt, wr_evt, tf_rd, ctl_rd, tf_wr, ctl_wr, bsy, drq, tf_wr_ok;
  logic        data_rd, data_wr, cmd_wr, reg7_wr, devctl_wr, srst_set, srst_rel, abort;
  logic        fill_word, wr_ack, wr_issue, last_word, sector_end, irq_set, irq_clr;
  logic        cmd_read, cmd_write, cmd_ident, cmd_ok;
  logic [8:0]  nsec;
  logic [27:0] lba28;
  logic [31:0] end_lba;
  logic        range_bad;
  logic [7:0]  status;
  logic [15:0] rd_mux;

  function automatic logic [15:0] id_word(input logic [7:0] idx);
    case (idx)
      8'd0:    return 16'h848A;
      8'd49:   return 16'h0200;
      8'd60:   return SECT32[15:0];
      8'd61:   return SECT32[31:16];
      default: return 16'h0000;
    endcase
  endfunction

  // The host reset pin is the reset source itself, so its synchronizer is never reset.
  always_ff @(posedge clk) begin
    ares_sync <= {ares_sync[0], ata_reset_n};
  end

  assign rst_any = reset | ~ares_sync[1];

  always_ff @(posedge clk) begin
    if (rst_any) begin
      {iord_s1, iord_s2, iord_s3} <= 3'b111;
      {iowr_s1, iowr_s2, iowr_s3} <= 3'b111;
      {cs_s1, cs_s2, cs_s3}       <= 6'h3F;
      {addr_s1, addr_s2, addr_s3} <= '0;
      {data_s1, data_s2, data_s3} <= '0;
    end else begin
      {iord_s1, iord_s2, iord_s3} <= {ata_iord_n, iord_s1, iord_s2};
      {iowr_s1, iowr_s2, iowr_s3} <= {ata_iowr_n, iowr_s1, iowr_s2};
      {cs_s1, cs_s2, cs_s3}       <= {ata_cs_n, cs_s1, cs_s2};
      {addr_s1, addr_s2, addr_s3} <= {ata_addr, addr_s1, addr_s2};
      {data_s1, data_s2, data_s3} <= {ata_data_in, data_s1, data_s2};
    end
  end

  // Reads decode from the newest sample; writes commit the sample taken while the strobe was low.
  assign rd_evt    = iord_s3 & ~iord_s2 & (cs_s2 != 2'b11);
  assign wr_evt    = ~iowr_s3 & iowr_s2 & (cs_s3 != 2'b11);
  assign tf_rd     = rd_evt & ~cs_s2[0];
  assign ctl_rd    = rd_evt & cs_s2[0];
  assign tf_wr     = wr_evt & ~cs_s3[0];
  assign ctl_wr    = wr_evt & cs_s3[0];
  assign bsy       = srst | (state == RD_FETCH) | (state == WR_FLUSH) | (state == ID_FILL);
  assign drq       = (state == RD_XFER) | (state == WR_XFER);
  assign tf_wr_ok  = tf_wr & ~bsy;
  assign data_rd   = tf_rd & (addr_s2 == 3'd0) & (state == RD_XFER);
  assign data_wr   = tf_wr_ok & (addr_s3 == 3'd0) & (state == WR_XFER);
  assign reg7_wr   = tf_wr_ok & (addr_s3 == 3'd7);
  assign cmd_wr    = reg7_wr & (state == IDLE);
  assign devctl_wr = ctl_wr & (addr_s3 == 3'd6);
  assign srst_set  = devctl_wr & data_s3[2];
  assign srst_rel  = devctl_wr & ~data_s3[2] & srst;
  assign abort     = srst | srst_set;

  assign last_word = (ptr == 8'hFF);
  assign fill_word = (state == RD_FETCH) & cmd_done & st_rd_valid;
  assign wr_ack    = (state == WR_FLUSH) & st_wr_valid & st_wr_ready;
  assign wr_issue  = (state == WR_FLUSH) & cmd_done & ~wcnt[8] & (~st_wr_valid | st_wr_ready);
  assign sector_end = ~abort & last_word & ((data_rd & ~ident) | wr_ack);

  assign nsec      = (count == 8'd0) ? 9'd256 : {1'b0, count};
  assign lba28     = {device[3:0], lba};
  assign end_lba   = {4'b0, lba28} + {23'b0, nsec};
  assign range_bad = end_lba > SECT32;

  assign cmd_read  = (data_s3[7:0] == 8'h20);
  assign cmd_write = (data_s3[7:0] == 8'h30);
`ifdef CF_ATA_DEVICE_IDENTIFY_EN
  assign cmd_ident = (data_s3[7:0] == 8'hEC);
`else
  assign cmd_ident = 1'b0;
`endif
  assign cmd_ok    = ((cmd_read | cmd_write) & ~range_bad) | cmd_ident;

  assign irq_set = ~abort & (((state != RD_XFER) & (next_state == RD_XFER)) |
                             (wr_ack & last_word) | (cmd_wr & ~cmd_ok));
  assign irq_clr = (tf_rd & (addr_s2 == 3'd7)) | reg7_wr;

  assign status = {bsy, 1'b1, 1'b0, 1'b1, drq, 2'b00, err};

  always_ff @(posedge clk) begin
    if (rst_any) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_wr && cmd_read && !range_bad)       next_state = RD_FETCH;
        else if (cmd_wr && cmd_write && !range_bad) next_state = WR_XFER;
        else if (cmd_wr && cmd_ident)               next_state = ID_FILL;
      end
      RD_FETCH: if (fill_word && last_word) next_state = RD_XFER;
      ID_FILL:  if (last_word) next_state = RD_XFER;
      RD_XFER:  if (data_rd && last_word) next_state = (ident || count == 8'd1) ? IDLE : RD_FETCH;
      WR_XFER:  if (data_wr && last_word) next_state = WR_FLUSH;
      WR_FLUSH: if (wr_ack && last_word) next_state = (count == 8'd1) ? IDLE : WR_XFER;
      default:  next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_comb begin
    rd_mux = 16'h00FF;
    if (!cs_s2[0]) begin
      case (addr_s2)
        3'd0:    rd_mux = (state == RD_XFER) ? buffer[ptr] : buffer[ptr - 8'd1];
        3'd1:    rd_mux = {8'h00, error};
        3'd2:    rd_mux = {8'h00, count};
        3'd3:    rd_mux = {8'h00, lba[7:0]};
        3'd4:    rd_mux = {8'h00, lba[15:8]};
        3'd5:    rd_mux = {8'h00, lba[23:16]};
        3'd6:    rd_mux = {8'h00, device};
        default: rd_mux = {8'h00, status};
      endcase
    end else if (addr_s2 == 3'd6) begin
      rd_mux = {8'h00, status};
    end
  end

  always_ff @(posedge clk) begin
    if (fill_word)             buffer[ptr] <= st_rd_data;
    else if (data_wr)          buffer[ptr] <= data_s3;
    else if (state == ID_FILL) buffer[ptr] <= id_word(ptr);
  end

  always_ff @(posedge clk) begin
    if (rst_any) begin
      count <= 8'h01; lba <= 24'h000001; device <= 8'h00; error <= 8'h01; err <= 1'b0;
      nien <= 1'b0; srst <= 1'b0; pending <= 1'b0; ident <= 1'b0;
      ptr <= '0; wcnt <= '0; cmd_done <= 1'b0; rd_done <= 1'b0;
      st_cmd_valid <= 1'b0; st_cmd_write <= 1'b0; st_cmd_lba <= '0;
      st_wr_valid <= 1'b0; st_wr_data <= '0; ata_data_out <= '0;
    end else begin
      if (rd_evt) begin
        ata_data_out <= rd_mux;
        rd_done <= 1'b1;
      end else if (iord_s2) begin
        rd_done <= 1'b0;
      end

      if (tf_wr_ok) begin
        case (addr_s3)
          3'd2: count <= data_s3[7:0];
          3'd3: lba[7:0] <= data_s3[7:0];
          3'd4: lba[15:8] <= data_s3[7:0];
          3'd5: lba[23:16] <= data_s3[7:0];
          3'd6: device <= data_s3[7:0];
          default: ;
        endcase
      end

      if (cmd_wr) begin
        ptr <= '0;
        ident <= cmd_ident;
        err <= ~cmd_ok;
        if (cmd_ok)                         error <= 8'h00;
        else if (cmd_read || cmd_write)     error <= 8'h10;
        else                                error <= 8'h04;
      end else if (fill_word || data_rd || data_wr || wr_ack || state == ID_FILL) begin
        ptr <= ptr + 8'd1;
      end

      if (sector_end) begin
        count <= count - 8'd1;
        {device[3:0], lba} <= lba28 + 28'd1;
      end

      if (irq_set)      pending <= 1'b1;
      else if (irq_clr) pending <= 1'b0;

      if (state != next_state) cmd_done <= 1'b0;
      if (data_wr && last_word) wcnt <= '0;

      // Storage handshakes are dropped immediately on soft reset; the store sees valids fall.
      if (abort) begin
        st_cmd_valid <= 1'b0;
        st_wr_valid  <= 1'b0;
        cmd_done     <= 1'b0;
      end else begin
        if ((state == RD_FETCH || state == WR_FLUSH) && !cmd_done && !st_cmd_valid) begin
          st_cmd_valid <= 1'b1;
          st_cmd_write <= (state == WR_FLUSH);
          st_cmd_lba   <= lba28;
        end else if (st_cmd_valid && st_cmd_ready) begin
          st_cmd_valid <= 1'b0;
          cmd_done     <= 1'b1;
        end
        if (wr_issue) begin
          st_wr_data  <= buffer[wcnt[7:0]];
          st_wr_valid <= 1'b1;
          wcnt        <= wcnt + 9'd1;
        end else if (wr_ack) begin
          st_wr_valid <= 1'b0;
        end
      end

      if (devctl_wr) begin
        nien <= data_s3[1];
        srst <= data_s3[2];
      end
      if (srst_rel) begin
        count <= 8'h01; lba <= 24'h000001; device <= 8'h00; error <= 8'h01;
        err <= 1'b0; pending <= 1'b0; ident <= 1'b0;
      end
    end
  end

  assign ata_intrq   = pending & ~nien;
  assign ata_data_oe = ~rst_any & (ata_cs_n != 2'b11) & ~ata_iord_n;
  assign ata_iordy   = rst_any | rd_done | ~((ata_cs_n != 2'b11) & ~ata_iord_n);

endmodule

// File: tb/tb_cf_ata_device.sv
// tb_cf_ata_device: directed PIO read/write, error, nIEN and SRST scenarios against cf_ata_device.
module tb_cf_ata_device;

  logic        clk = 1'b0;
  logic        reset;
  logic        ata_reset_n;
  logic [1:0]  ata_cs_n;
  logic [2:0]  ata_addr;
  logic        ata_iord_n, ata_iowr_n;
  logic [15:0] ata_data_in;
  logic [15:0] ata_data_out;
  logic        ata_data_oe, ata_intrq, ata_iordy;
  logic        st_cmd_valid, st_cmd_ready, st_cmd_write;
  logic [27:0] st_cmd_lba;
  logic [15:0] st_rd_data;
  logic        st_rd_valid;
  logic [15:0] st_wr_data;
  logic        st_wr_valid, st_wr_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cf_ata_device #(.SECTORS(65536)) dut (
    .clk(clk), .reset(reset), .ata_reset_n(ata_reset_n),
    .ata_cs_n(ata_cs_n), .ata_addr(ata_addr),
    .ata_iord_n(ata_iord_n), .ata_iowr_n(ata_iowr_n),
    .ata_data_in(ata_data_in), .ata_data_out(ata_data_out), .ata_data_oe(ata_data_oe),
    .ata_intrq(ata_intrq), .ata_iordy(ata_iordy),
    .st_cmd_valid(st_cmd_valid), .st_cmd_ready(st_cmd_ready), .st_cmd_write(st_cmd_write),
    .st_cmd_lba(st_cmd_lba), .st_rd_data(st_rd_data), .st_rd_valid(st_rd_valid),
    .st_wr_data(st_wr_data), .st_wr_valid(st_wr_valid), .st_wr_ready(st_wr_ready)
  );

  task automatic host_read(input logic [1:0] cs, input logic [2:0] addr, output logic [15:0] d);
    @(negedge clk);
    ata_cs_n = cs; ata_addr = addr; ata_iord_n = 1'b0;
    repeat (5) @(negedge clk);
    d = ata_data_out;
    ata_iord_n = 1'b1; ata_cs_n = 2'b11;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_write(input logic [1:0] cs, input logic [2:0] addr, input logic [15:0] d);
    @(negedge clk);
    ata_cs_n = cs; ata_addr = addr; ata_data_in = d; ata_iowr_n = 1'b0;
    repeat (5) @(negedge clk);
    ata_iowr_n = 1'b1;
    repeat (3) @(negedge clk);
    ata_cs_n = 2'b11;
    repeat (3) @(negedge clk);
  endtask

  task automatic program_tf(input logic [7:0] cnt, input logic [27:0] lba);
    host_write(2'b10, 3'd2, {8'h00, cnt});
    host_write(2'b10, 3'd3, {8'h00, lba[7:0]});
    host_write(2'b10, 3'd4, {8'h00, lba[15:8]});
    host_write(2'b10, 3'd5, {8'h00, lba[23:16]});
    host_write(2'b10, 3'd6, {12'h000, lba[27:24]});
  endtask

  task automatic serve_cmd(output logic seen, output logic [27:0] lba, output logic wr);
    seen = 1'b0; lba = '0; wr = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (st_cmd_valid) seen = 1'b1;
    end
    if (seen) begin
      lba = st_cmd_lba; wr = st_cmd_write;
      st_cmd_ready = 1'b1;
      @(negedge clk);
      st_cmd_ready = 1'b0;
    end
  endtask

  task automatic stream_sector(input logic [27:0] lba);
    for (int i = 0; i < 256; i++) begin
      st_rd_valid = 1'b1;
      st_rd_data  = {lba[7:0], 8'(i)};
      @(negedge clk);
    end
    st_rd_valid = 1'b0;
  endtask

  task automatic wait_intrq(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ata_intrq) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic [15:0] exp_regs [6] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0050};
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (ata_iordy !== 1'b1) begin errors++; $display("[TB] FAIL reset_iordy: got %b expected 1", ata_iordy); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ata_intrq !== 1'b0) begin errors++; $display("[TB] FAIL reset_intrq: got %b expected 0", ata_intrq); end
    checks++; if (ata_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", ata_data_oe); end
    checks++; if (ata_data_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 0000", ata_data_out); end
    checks++; if (st_cmd_valid !== 1'b0 || st_wr_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valids: got cmd=%b wr=%b expected 0 0", st_cmd_valid, st_wr_valid);
    end
    for (int r = 0; r < 6; r++) begin
      host_read(2'b10, 3'(r + 2), d);
      checks++; if (d !== exp_regs[r]) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", r + 2, d, exp_regs[r]); end
    end
  endtask

  task automatic test_read_timing();
    @(negedge clk);
    ata_cs_n = 2'b10; ata_addr = 3'd3; ata_iord_n = 1'b0;
    #1;
    checks++; if (ata_data_oe !== 1'b1 || ata_iordy !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_strobe_pins: got oe=%b iordy=%b expected 1 0", ata_data_oe, ata_iordy);
    end
    repeat (2) @(negedge clk);
    checks++; if (ata_data_out !== 16'h0050 || ata_iordy !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_latency_early: got data=%h iordy=%b expected 0050 0", ata_data_out, ata_iordy);
    end
    @(negedge clk);
    checks++; if (ata_data_out !== 16'h0001 || ata_iordy !== 1'b1) begin
      errors++; $display("[TB] FAIL rd_latency_load: got data=%h iordy=%b expected 0001 1", ata_data_out, ata_iordy);
    end
    repeat (2) @(negedge clk);
    ata_iord_n = 1'b1; ata_cs_n = 2'b11;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_read_sectors();
    logic seen, wr;
    logic [27:0] lba;
    logic [15:0] d;
    program_tf(8'd2, 28'd5);
    host_write(2'b10, 3'd7, 16'h0020);
    for (int s = 0; s < 2; s++) begin
      serve_cmd(seen, lba, wr);
      checks++; if (seen !== 1'b1 || lba !== 28'(5 + s) || wr !== 1'b0) begin
        errors++; $display("[TB] FAIL rd_cmd%0d: got seen=%b lba=%0d write=%b expected 1 %0d 0", s, seen, lba, wr, 5 + s);
      end
      stream_sector(28'(5 + s));
      wait_intrq(seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rd_intrq%0d: got 0 expected 1", s); end
      host_read(2'b10, 3'd7, d);
      checks++; if (d !== 16'h0058) begin errors++; $display("[TB] FAIL rd_drq_status%0d: got %h expected 0058", s, d); end
      for (int i = 0; i < 256; i++) begin
        host_read(2'b10, 3'd0, d);
        checks++; if (d !== 16'(16'h0500 + 16'h0100 * s + i)) begin
          errors++; $display("[TB] FAIL rd_word s%0d w%0d: got %h expected %h", s, i, d, 16'(16'h0500 + 16'h0100 * s + i));
        end
      end
    end
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("[TB] FAIL rd_final_status: got %h expected 0050", d); end
  endtask

  task automatic test_write_sector();
    logic seen, wr, tog;
    logic [27:0] lba;
    logic [15:0] d;
    int got;
    program_tf(8'd1, 28'd7);
    host_write(2'b10, 3'd7, 16'h0030);
    checks++; if (ata_intrq !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_early_intrq: got 1 expected 0"); end
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0058) begin errors++; $display("[TB] FAIL wr_drq_status: got %h expected 0058", d); end
    for (int i = 0; i < 256; i++) host_write(2'b10, 3'd0, 16'(16'hA000 + i));
    serve_cmd(seen, lba, wr);
    checks++; if (seen !== 1'b1 || lba !== 28'd7 || wr !== 1'b1) begin
      errors++; $display("[TB] FAIL wr_cmd: got seen=%b lba=%0d write=%b expected 1 7 1", seen, lba, wr);
    end
    got = 0; tog = 1'b0;
    for (int cyc = 0; cyc < 3000 && got < 256; cyc++) begin
      @(negedge clk);
      tog = ~tog;
      st_wr_ready = tog;
      if (st_wr_valid && st_wr_ready) begin
        checks++; if (st_wr_data !== 16'(16'hA000 + got)) begin
          errors++; $display("[TB] FAIL wr_word%0d: got %h expected %h", got, st_wr_data, 16'(16'hA000 + got));
        end
        got++;
      end
    end
    @(negedge clk);
    st_wr_ready = 1'b0;
    checks++; if (got != 256) begin errors++; $display("[TB] FAIL wr_word_count: got %0d expected 256", got); end
    wait_intrq(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL wr_intrq: got 0 expected 1"); end
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0050 || ata_intrq !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_final_status: got %h intrq=%b expected 0050 0", d, ata_intrq);
    end
  endtask

  task automatic test_idnf();
    logic [15:0] d;
    logic saw_valid;
    program_tf(8'd2, 28'd65535);
    host_write(2'b10, 3'd7, 16'h0030);
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (st_cmd_valid) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("[TB] FAIL idnf_no_cmd: got 1 expected 0"); end
    checks++; if (ata_intrq !== 1'b1) begin errors++; $display("[TB] FAIL idnf_intrq: got 0 expected 1"); end
    host_read(2'b10, 3'd1, d);
    checks++; if (d !== 16'h0010) begin errors++; $display("[TB] FAIL idnf_error: got %h expected 0010", d); end
    host_read(2'b01, 3'd6, d);
    checks++; if (d !== 16'h0051 || ata_intrq !== 1'b1) begin
      errors++; $display("[TB] FAIL idnf_altstatus: got %h intrq=%b expected 0051 1", d, ata_intrq);
    end
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0051 || ata_intrq !== 1'b0) begin
      errors++; $display("[TB] FAIL idnf_status: got %h intrq=%b expected 0051 0", d, ata_intrq);
    end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    program_tf(8'd1, 28'd1);
    host_write(2'b10, 3'd7, 16'h0099);
    host_read(2'b10, 3'd1, d);
    checks++; if (d !== 16'h0004) begin errors++; $display("[TB] FAIL abrt_error: got %h expected 0004", d); end
    host_read(2'b01, 3'd0, d);
    checks++; if (d !== 16'h00FF) begin errors++; $display("[TB] FAIL ctl_other_reg: got %h expected 00FF", d); end
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0051) begin errors++; $display("[TB] FAIL abrt_status: got %h expected 0051", d); end
  endtask

  task automatic test_nien();
    logic seen, wr;
    logic [27:0] lba;
    logic [15:0] d;
    logic saw_irq;
    host_write(2'b01, 3'd6, 16'h0002);
    program_tf(8'd1, 28'd9);
    host_write(2'b10, 3'd7, 16'h0020);
    serve_cmd(seen, lba, wr);
    stream_sector(lba);
    saw_irq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ata_intrq) saw_irq = 1'b1;
    end
    checks++; if (saw_irq !== 1'b0) begin errors++; $display("[TB] FAIL nien_intrq: got 1 expected 0"); end
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0058) begin errors++; $display("[TB] FAIL nien_status: got %h expected 0058", d); end
    host_write(2'b01, 3'd6, 16'h0006);
    host_write(2'b01, 3'd6, 16'h0000);
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("[TB] FAIL nien_srst_status: got %h expected 0050", d); end
  endtask

  task automatic test_srst();
    logic seen;
    logic [15:0] d;
    program_tf(8'd1, 28'd3);
    host_write(2'b10, 3'd7, 16'h0020);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (st_cmd_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1 || st_cmd_lba !== 28'd3) begin
      errors++; $display("[TB] FAIL srst_cmd: got seen=%b lba=%0d expected 1 3", seen, st_cmd_lba);
    end
    host_write(2'b01, 3'd6, 16'h0004);
    checks++; if (st_cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL srst_valid_drop: got 1 expected 0"); end
    host_read(2'b01, 3'd6, d);
    checks++; if (d[7] !== 1'b1) begin errors++; $display("[TB] FAIL srst_bsy: got %h expected bit7 set", d); end
    host_write(2'b01, 3'd6, 16'h0000);
    host_read(2'b10, 3'd7, d);
    checks++; if (d !== 16'h0050) begin errors++; $display("[TB] FAIL srst_status: got %h expected 0050", d); end
    host_read(2'b10, 3'd3, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL srst_lba: got %h expected 0001", d); end
    host_read(2'b10, 3'd2, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("[TB] FAIL srst_count: got %h expected 0001", d); end
  endtask

  initial begin
    reset = 1'b1; ata_reset_n = 1'b1; ata_cs_n = 2'b11; ata_addr = '0;
    ata_iord_n = 1'b1; ata_iowr_n = 1'b1; ata_data_in = '0;
    st_cmd_ready = 1'b0; st_rd_data = '0; st_rd_valid = 1'b0; st_wr_ready = 1'b0;
    test_reset();
    test_read_timing();
    test_read_sectors();
    test_write_sector();
    test_idnf();
    test_abort();
    test_nien();
    test_srst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
